// File: rtl/winddir_tof_xcorr.sv
// Frame buffer plus per-axis cross-correlator that reports the lag of the correlation peak.
// Optional: define WINDDIR_TOF_PEAK_EN to add the 'peak' output (best correlation value per pair).
module winddir_tof_xcorr #(
   parameter int NPAIR  = 2,
   parameter int DW     = 12,
   parameter int DEPTH  = 64,
   parameter int MAXLAG = 16,
   parameter int LW     = 8,
   parameter int ACCW   = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   endata,
   input  logic [NPAIR*DW-1:0]    rx_uw,
   input  logic [NPAIR*DW-1:0]    rx_dw,
   output logic [NPAIR*LW-1:0]    lag,
   output logic                   lag_valid,
   output logic                   busy,
   output logic [7:0]             drop_cnt
`ifdef WINDDIR_TOF_PEAK_EN
   ,
   output logic [NPAIR*ACCW-1:0]  peak
`endif
);

   localparam int NW = $clog2(DEPTH);
   localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int SW = ((NW > LW) ? NW : LW) + 2;
   localparam logic [NW-1:0]        N_LAST  = NW'(DEPTH - 1);
   localparam logic [PW-1:0]        P_LAST  = PW'(NPAIR - 1);
   localparam logic signed [LW-1:0] LAG_MIN = LW'(-MAXLAG);
   localparam logic signed [LW-1:0] LAG_MAX = LW'(MAXLAG);
   localparam logic signed [SW-1:0] DEPTH_S = SW'(DEPTH);

   typedef enum logic [1:0] {CAPTURE, COMPUTE, DONE} state_t;

   state_t state;
   logic [NW-1:0] wr_idx;
   logic signed [DW-1:0] uw_mem [NPAIR][DEPTH];
   logic signed [DW-1:0] dw_mem [NPAIR][DEPTH];

   logic                   issue;
   logic [PW-1:0]          p_cnt;
   logic signed [LW-1:0]   lag_cnt;
   logic [NW-1:0]          n_cnt;

   logic                   s1_valid, s1_first, s1_last;
   logic [PW-1:0]          s1_pair;
   logic signed [LW-1:0]   s1_lag;
   logic signed [DW-1:0]   op_a, op_b;

   logic                   s2_valid, s2_last;
   logic [PW-1:0]          s2_pair;
   logic signed [LW-1:0]   s2_lag;
   logic signed [ACCW-1:0] acc;

   logic signed [ACCW-1:0] best_val [NPAIR];
   logic signed [LW-1:0]   best_lag [NPAIR];

   logic signed [SW-1:0]   didx;
   logic                   d_in;
   logic signed [2*DW-1:0] mul;
   logic signed [ACCW-1:0] acc_base, acc_nxt;

   // dw index n+L; out-of-frame taps read as zero (zero padding, no wrap)
   always_comb begin
      didx     = $signed(SW'({1'b0, n_cnt})) + SW'(lag_cnt);
      d_in     = !didx[SW-1] && (didx < DEPTH_S);
      mul      = op_a * op_b;
      acc_base = s1_first ? ACCW'(0) : acc;
      acc_nxt  = acc_base + ACCW'(mul);
   end

   // NOTE: sample storage has no reset; every entry is rewritten before it is read.
   always_ff @(posedge clock) begin
      if (state == CAPTURE && endata) begin
         for (int p = 0; p < NPAIR; p++) begin
            uw_mem[p][wr_idx] <= rx_uw[p*DW +: DW];
            dw_mem[p][wr_idx] <= rx_dw[p*DW +: DW];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= CAPTURE;
         wr_idx    <= '0;
         lag       <= '0;
         lag_valid <= 1'b0;
         busy      <= 1'b0;
         drop_cnt  <= '0;
         issue     <= 1'b0;
         p_cnt     <= '0;
         lag_cnt   <= LAG_MIN;
         n_cnt     <= '0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_pair   <= '0;
         s1_lag    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_pair   <= '0;
         s2_lag    <= '0;
         acc       <= '0;
         for (int p = 0; p < NPAIR; p++) begin
            best_val[p] <= '0;
            best_lag[p] <= '0;
         end
`ifdef WINDDIR_TOF_PEAK_EN
         peak      <= '0;
`endif
      end else begin
         lag_valid <= 1'b0;
         if (endata && state != CAPTURE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         // MAC sequencer: pair outer, lag middle, sample index inner
         if (issue) begin
            n_cnt <= n_cnt + NW'(1);
            if (n_cnt == N_LAST) begin
               if (lag_cnt == LAG_MAX) begin
                  lag_cnt <= LAG_MIN;
                  if (p_cnt == P_LAST) issue <= 1'b0;
                  else                 p_cnt <= p_cnt + PW'(1);
               end else begin
                  lag_cnt <= lag_cnt + LW'(1);
               end
            end
         end

         s1_valid <= issue;
         if (issue) begin
            op_a     <= uw_mem[p_cnt][n_cnt];
            op_b     <= d_in ? dw_mem[p_cnt][didx[NW-1:0]] : '0;
            s1_first <= (n_cnt == '0);
            s1_last  <= (n_cnt == N_LAST);
            s1_pair  <= p_cnt;
            s1_lag   <= lag_cnt;
         end

         s2_valid <= s1_valid;
         if (s1_valid) begin
            acc     <= acc_nxt;
            s2_last <= s1_last;
            s2_pair <= s1_pair;
            s2_lag  <= s1_lag;
         end

         // strict greater-than keeps the most negative lag on ties
         if (s2_valid && s2_last && (s2_lag == LAG_MIN || acc > best_val[s2_pair])) begin
            best_val[s2_pair] <= acc;
            best_lag[s2_pair] <= s2_lag;
         end

         case (state)
            CAPTURE: begin
               if (endata) begin
                  wr_idx <= wr_idx + NW'(1);
                  if (wr_idx == N_LAST) begin
                     state   <= COMPUTE;
                     busy    <= 1'b1;
                     issue   <= 1'b1;
                     p_cnt   <= '0;
                     lag_cnt <= LAG_MIN;
                     n_cnt   <= '0;
                  end
               end
            end
            COMPUTE: begin
               if (!issue && !s1_valid && !s2_valid) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  lag_valid <= 1'b1;
                  for (int p = 0; p < NPAIR; p++) begin
                     lag[p*LW +: LW] <= best_lag[p];
`ifdef WINDDIR_TOF_PEAK_EN
                     peak[p*ACCW +: ACCW] <= best_val[p];
`endif
                  end
               end
            end
            default: state <= CAPTURE;
         endcase
      end
   end

endmodule

// File: tb/tb_winddir_tof_xcorr.sv
// Directed bench for winddir_tof_xcorr: default instance plus a 3-pair, 32-sample, +/-8 lag instance.
// Peak checks are active when WINDDIR_TOF_PEAK_EN is defined.
module tb_winddir_tof_xcorr;

   localparam int NPAIR = 2, DW = 12, DEPTH = 64, MAXLAG = 16, LW = 8, ACCW = 32;
   localparam int N2 = 3, D2 = 32, M2 = 8;
   localparam int BOUND1 = NPAIR*(2*MAXLAG+1)*(DEPTH+4)+4;
   localparam int BOUND2 = N2*(2*M2+1)*(D2+4)+4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic endata = 1'b0, endata2 = 1'b0;
   logic [NPAIR*DW-1:0] rx_uw = '0, rx_dw = '0;
   logic [N2*DW-1:0]    rx_uw2 = '0, rx_dw2 = '0;
   logic [NPAIR*LW-1:0] lag;
   logic [N2*LW-1:0]    lag2;
   logic lag_valid, busy, lag_valid2, busy2;
   logic [7:0] drop_cnt, drop_cnt2;
`ifdef WINDDIR_TOF_PEAK_EN
   logic [NPAIR*ACCW-1:0] peak;
   logic [N2*ACCW-1:0]    peak2;
`endif

   int tests = 0, errors = 0, valid_cnt = 0, v0;
   logic signed [DW-1:0] uw_f [N2][DEPTH];
   logic signed [DW-1:0] dw_f [N2][DEPTH];

   winddir_tof_xcorr #(.NPAIR(NPAIR), .DW(DW), .DEPTH(DEPTH), .MAXLAG(MAXLAG), .LW(LW), .ACCW(ACCW)) dut (
      .clock(clock), .reset(reset), .endata(endata), .rx_uw(rx_uw), .rx_dw(rx_dw),
      .lag(lag), .lag_valid(lag_valid), .busy(busy), .drop_cnt(drop_cnt)
`ifdef WINDDIR_TOF_PEAK_EN
      , .peak(peak)
`endif
   );

   winddir_tof_xcorr #(.NPAIR(N2), .DW(DW), .DEPTH(D2), .MAXLAG(M2), .LW(LW), .ACCW(ACCW)) dut2 (
      .clock(clock), .reset(reset), .endata(endata2), .rx_uw(rx_uw2), .rx_dw(rx_dw2),
      .lag(lag2), .lag_valid(lag_valid2), .busy(busy2), .drop_cnt(drop_cnt2)
`ifdef WINDDIR_TOF_PEAK_EN
      , .peak(peak2)
`endif
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (lag_valid) valid_cnt++;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_frame();
      for (int p = 0; p < N2; p++)
         for (int n = 0; n < DEPTH; n++) begin
            uw_f[p][n] = '0;
            dw_f[p][n] = '0;
         end
   endtask

   // dw[n] = uw[n-d]  ->  expected peak lag +d
   task automatic pulse(input int p, input int n0, input int d);
      uw_f[p][n0]   = 12'sd1000;
      dw_f[p][n0+d] = 12'sd1000;
   endtask

   task automatic send_frame(input bit sel);
      for (int n = 0; n < (sel ? D2 : DEPTH); n++) begin
         if (sel) begin
            for (int p = 0; p < N2; p++) begin
               rx_uw2[p*DW +: DW] = uw_f[p][n];
               rx_dw2[p*DW +: DW] = dw_f[p][n];
            end
            endata2 = 1'b1;
         end else begin
            for (int p = 0; p < NPAIR; p++) begin
               rx_uw[p*DW +: DW] = uw_f[p][n];
               rx_dw[p*DW +: DW] = dw_f[p][n];
            end
            endata = 1'b1;
         end
         @(posedge clock); #1;
         endata  = 1'b0;
         endata2 = 1'b0;
         repeat (9) @(posedge clock);
         #1;
      end
   endtask

   // called 9 clocks after the frame-completing strobe; c+8 is the COMPUTE length
   task automatic wait_valid(input bit sel, input string tag, input int bound);
      int c = 0;
      while (((sel ? lag_valid2 : lag_valid) == 1'b0) && c < 6000) begin
         @(negedge clock);
         c++;
      end
      check({tag, "_valid"}, sel ? lag_valid2 : lag_valid, 1);
      check({tag, "_dur"}, (c + 8) <= bound, 1);
   endtask

   task automatic check_lag(input string tag, input int e0, input int e1);
      check({tag, "_lag0"}, $signed(lag[0 +: LW]), e0);
      check({tag, "_lag1"}, $signed(lag[LW +: LW]), e1);
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      check("rst_lag", lag, 0);
      check("rst_valid", lag_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_cnt, 0);
`ifdef WINDDIR_TOF_PEAK_EN
      check("rst_peak", peak, 0);
`endif
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // identical ramp -> zero lag
      clear_frame();
      for (int p = 0; p < NPAIR; p++)
         for (int n = 0; n < DEPTH; n++) begin
            uw_f[p][n] = 12'(n - 32);
            dw_f[p][n] = 12'(n - 32);
         end
      send_frame(0);
      check("ramp_busy", busy, 1);
      wait_valid(0, "ramp", BOUND1);
      check_lag("ramp", 0, 0);
      repeat (20) @(negedge clock);
      check("ramp_pulses", valid_cnt, 1);
      check("ramp_drop", drop_cnt, 0);
      check("ramp_hold", $signed(lag[0 +: LW]), 0);
      @(posedge clock); #1;

      // delayed / advanced pulses
      clear_frame();
      pulse(0, 20, 3);
      pulse(1, 20, -5);
      send_frame(0);
      wait_valid(0, "pulse", BOUND1);
      check_lag("pulse", 3, -5);
`ifdef WINDDIR_TOF_PEAK_EN
      check("pulse_peak0", $signed(peak[0 +: ACCW]), 1000000);
      check("pulse_peak1", $signed(peak[ACCW +: ACCW]), 1000000);
`endif
      @(posedge clock); #1;

      // all-zero frame -> ties resolve to most negative lag
      clear_frame();
      send_frame(0);
      wait_valid(0, "zero", BOUND1);
      check_lag("zero", -16, -16);
`ifdef WINDDIR_TOF_PEAK_EN
      check("zero_peak", peak, 0);
`endif
      @(posedge clock); #1;

      // strobes kept running through COMPUTE
      clear_frame();
      pulse(0, 30, 7);
      pulse(1, 30, -2);
      send_frame(0);
      for (int k = 0; k < 5; k++) begin
         endata = 1'b1;
         @(posedge clock); #1;
         endata = 1'b0;
         repeat (9) @(posedge clock);
         #1;
      end
      @(negedge clock);
      check("drop_5", drop_cnt, 5);
      check("drop_busy", busy, 1);
      @(posedge clock); #1;
      v0 = valid_cnt;
      for (int k = 0; k < 600 && valid_cnt == v0; k++) begin
         endata = 1'b1;
         @(posedge clock); #1;
         endata = 1'b0;
         repeat (9) @(posedge clock);
         #1;
      end
      check("drop_pulses", valid_cnt, v0 + 1);
      check("drop_sat", drop_cnt, 255);
      check_lag("drop", 7, -2);
      clear_frame();
      pulse(0, 25, -3);
      pulse(1, 25, 6);
      send_frame(0);
      wait_valid(0, "next", BOUND1);
      check_lag("next", -3, 6);
      check("next_drop", drop_cnt, 255);
      @(posedge clock); #1;

      // asynchronous reset mid-COMPUTE
      clear_frame();
      pulse(0, 40, 4);
      pulse(1, 40, -1);
      send_frame(0);
      repeat (1000) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check("arst_lag", lag, 0);
      check("arst_busy", busy, 0);
      check("arst_drop", drop_cnt, 0);
      check("arst_valid", lag_valid, 0);
      v0 = valid_cnt;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      repeat (5000) @(posedge clock);
      #1;
      check("arst_no_valid", valid_cnt, v0);
      send_frame(0);
      wait_valid(0, "arst", BOUND1);
      check_lag("arst", 4, -1);
      @(posedge clock); #1;

      // 3-pair, 32-sample, +/-8 instance
      clear_frame();
      pulse(0, 10, 2);
      pulse(1, 16, 0);
      pulse(2, 12, -8);
      send_frame(1);
      wait_valid(1, "p3", BOUND2);
      check("p3_lag0", $signed(lag2[0 +: LW]), 2);
      check("p3_lag1", $signed(lag2[LW +: LW]), 0);
      check("p3_lag2", $signed(lag2[2*LW +: LW]), -8);
      check("p3_drop", drop_cnt2, 0);
`ifdef WINDDIR_TOF_PEAK_EN
      check("p3_peak2", $signed(peak2[2*ACCW +: ACCW]), 1000000);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
